acc_rd_seq: RTL and testbench

Read sequencer that sits directly upstream of the saturating accumulator. On a start pulse it issues a burst of N consecutive single-port SRAM reads and drives the accumulator's input-select and output-enable controls, aligned to the SRAM's one-cycle read latency. The saturated sum of the N words appears on the accumulator output for exactly one cycle, coincident with `oDone`.

---
 rtl/acc_pkg.sv | 25 ++
 rtl/acc_rd_seq_if.sv | 44 ++++
 rtl/acc_rd_seq.sv | 119 +++++++++++
 tb/tb_acc_rd_seq.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// -----------------------------------------------------------------------------
// acc_pkg
// Shared definitions for the accumulator read path: sequencer state encoding,
// accumulator input-select codes and default address / burst-length widths.
// -----------------------------------------------------------------------------
package acc_pkg;

   // Default SRAM address width (2^ACC_ADDR_W words) and burst-length width.
   localparam int ACC_ADDR_W = 4;
   localparam int ACC_LEN_W  = 5;

   // Accumulator input select: CLR holds the accumulator at zero,
   // ACC adds the SRAM read data into it.
   localparam logic [1:0] ACC_SEL_CLR = 2'b00;
   localparam logic [1:0] ACC_SEL_ACC = 2'b11;

   // Read sequencer states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } acc_state_t;

endpackage : acc_pkg

// File: rtl/acc_rd_seq_if.sv
// -----------------------------------------------------------------------------
// acc_rd_seq_if
// Control / SRAM-side bundle of the accumulator read sequencer.
//   iStart    : start request (sampled in IDLE only)
//   iBaseAddr : first read address, captured with iStart
//   iLen      : burst length N (1..2^ADDR_W), captured with iStart
//   iAbort    : synchronous abort of the current burst
//   oRdEn     : SRAM read enable
//   oAddr     : SRAM read address
//   oInSel    : accumulator input select (00 clear, 11 accumulate)
//   oEnOut    : accumulator final-output enable
//   oBusy     : sequencer not in IDLE
//   oDone     : one-cycle pulse aligned with the accumulator result
// Modports: slave = the sequencer, master = the controlling side.
// -----------------------------------------------------------------------------
interface acc_rd_seq_if
   import acc_pkg::*;
#(
   parameter int ADDR_W = ACC_ADDR_W,
   parameter int LEN_W  = ACC_LEN_W
);

   logic              iStart;
   logic [ADDR_W-1:0] iBaseAddr;
   logic [LEN_W-1:0]  iLen;
   logic              iAbort;
   logic              oRdEn;
   logic [ADDR_W-1:0] oAddr;
   logic [1:0]        oInSel;
   logic              oEnOut;
   logic              oBusy;
   logic              oDone;

   modport slave (
      input  iStart, iBaseAddr, iLen, iAbort,
      output oRdEn, oAddr, oInSel, oEnOut, oBusy, oDone
   );

   modport master (
      output iStart, iBaseAddr, iLen, iAbort,
      input  oRdEn, oAddr, oInSel, oEnOut, oBusy, oDone
   );

endinterface : acc_rd_seq_if

// File: rtl/acc_rd_seq.sv
// -----------------------------------------------------------------------------
// acc_rd_seq
// Read sequencer feeding a saturating accumulator. A start pulse launches a
// burst of N consecutive SRAM reads (address wraps modulo 2^ADDR_W); the
// accumulator controls are delayed one cycle to line up with the SRAM read
// latency so the final sum appears together with oDone, N+2 cycles after the
// start was sampled. All outputs are registered.
// Ports:
//   iClk : clock, rising edge
//   iRsn : asynchronous active-low reset
//   bus  : acc_rd_seq_if.slave (start/abort controls, SRAM and accumulator
//          controls, status)
// -----------------------------------------------------------------------------
module acc_rd_seq
   import acc_pkg::*;
#(
   parameter int ADDR_W = ACC_ADDR_W,
   parameter int LEN_W  = ACC_LEN_W
) (
   input logic         iClk,
   input logic         iRsn,
   acc_rd_seq_if.slave bus
);

   acc_state_t        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;      // reads remaining after the current one
   logic              rd_en_q, rd_en_d;
   logic              vld_q, vld_d;      // SRAM data valid (read enable delayed)
   logic              last_q, last_d;    // valid data is the final word
   logic [1:0]        in_sel_q, in_sel_d;
   logic              en_out_q, en_out_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;
   logic              len_ok;

   // Legal length is 1..2^ADDR_W; compared at 32 bits so LEN_W == ADDR_W works.
   assign len_ok = (bus.iLen != '0) && (32'(bus.iLen) <= (32'd1 << ADDR_W));

   always_ff @(posedge iClk or negedge iRsn) begin
      if (!iRsn) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         cnt_q    <= '0;
         rd_en_q  <= 1'b0;
         vld_q    <= 1'b0;
         last_q   <= 1'b0;
         in_sel_q <= ACC_SEL_CLR;
         en_out_q <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         cnt_q    <= cnt_d;
         rd_en_q  <= rd_en_d;
         vld_q    <= vld_d;
         last_q   <= last_d;
         in_sel_q <= in_sel_d;
         en_out_q <= en_out_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      // One-cycle pipe behind the read enable; the last read is the one
      // issued with no reads remaining.
      vld_d   = rd_en_q;
      last_d  = rd_en_q && (cnt_q == '0);
      done_d  = en_out_q;

      unique case (state_q)
         IDLE: begin
            if (bus.iStart && len_ok) begin
               state_d = ISSUE;
               addr_d  = bus.iBaseAddr;
               cnt_d   = bus.iLen - LEN_W'(1);
            end
         end
         ISSUE: begin
            if (cnt_q == '0) begin
               state_d = WAIT;
            end else begin
               addr_d = addr_q + ADDR_W'(1);
               cnt_d  = cnt_q - LEN_W'(1);
            end
         end
         WAIT:    state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Abort beats everything, including a start in the same cycle; clearing
      // the valid pipe drops in-flight data and suppresses oEnOut/oDone.
      if (bus.iAbort) begin
         state_d = IDLE;
         vld_d   = 1'b0;
         last_d  = 1'b0;
         done_d  = 1'b0;
      end

      rd_en_d  = (state_d == ISSUE);
      in_sel_d = vld_d ? ACC_SEL_ACC : ACC_SEL_CLR;
      en_out_d = vld_d && last_d;
      busy_d   = (state_d != IDLE);
   end

   assign bus.oRdEn  = rd_en_q;
   assign bus.oAddr  = addr_q;
   assign bus.oInSel = in_sel_q;
   assign bus.oEnOut = en_out_q;
   assign bus.oDone  = done_q;
   assign bus.oBusy  = busy_q;

endmodule : acc_rd_seq

// File: tb/tb_acc_rd_seq.sv
// -----------------------------------------------------------------------------
// tb_acc_rd_seq
// SRAM model -> acc_rd_seq -> saturating accumulator in series. Expected
// per-cycle control values and burst sums come from the timing rules and a
// plain clamped running sum over the memory contents.
// -----------------------------------------------------------------------------
module tb_acc_rd_seq;
   import acc_pkg::*;

   localparam int AW    = 4;
   localparam int LW    = 5;
   localparam int DEPTH = 1 << AW;

   logic clk;
   logic rsn;

   acc_rd_seq_if #(.ADDR_W(AW), .LEN_W(LW)) bus ();

   acc_rd_seq #(.ADDR_W(AW), .LEN_W(LW)) dut (
      .iClk (clk),
      .iRsn (rsn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- integration harness: SRAM + accumulator ----------------
   logic [15:0] mem [DEPTH];
   logic [15:0] rdata;
   logic [15:0] acc;
   logic [15:0] acc_out;

   function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
      int s;
      s = int'($signed(a)) + int'($signed(b));
      if (s > 32767)  return 16'h7FFF;
      if (s < -32768) return 16'h8000;
      return 16'(s);
   endfunction

   always @(posedge clk or negedge rsn) begin
      if (!rsn) begin
         rdata   <= '0;
         acc     <= '0;
         acc_out <= '0;
      end else begin
         if (bus.oRdEn) rdata <= mem[bus.oAddr];
         acc     <= (bus.oInSel == 2'b11) ? sat_add(acc, rdata) : 16'h0000;
         acc_out <= bus.oEnOut ? sat_add(acc, rdata) : 16'h0000;
      end
   end

   // ---------------- checking ----------------
   int n_pass  = 0;
   int n_total = 0;
   int burst_id = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: clamped running sum of N words starting at base, wrapping.
   function automatic logic [15:0] burst_sum(input int base, input int n);
      int s;
      s = 0;
      for (int k = 0; k < n; k++) begin
         s = s + int'($signed(mem[(base + k) % DEPTH]));
         if (s > 32767)  s = 32767;
         if (s < -32768) s = -32768;
      end
      return 16'(s);
   endfunction

   task automatic check_idle(input string tag);
      check({tag, " rden"},   32'(bus.oRdEn),  32'd0);
      check({tag, " insel"},  32'(bus.oInSel), 32'd0);
      check({tag, " enout"},  32'(bus.oEnOut), 32'd0);
      check({tag, " done"},   32'(bus.oDone),  32'd0);
      check({tag, " busy"},   32'(bus.oBusy),  32'd0);
      check({tag, " accout"}, 32'(acc_out),    32'd0);
   endtask

   // Expected outputs at cycle Tt of a burst (t counted from the start edge).
   task automatic check_cycle(input int t, input int base, input int n, input logic [15:0] sum);
      string tg;
      tg = $sformatf("b%0d t%0d", burst_id, t);
      check({tg, " rden"},  32'(bus.oRdEn),  32'(t <= n));
      if (t <= n)
         check({tg, " addr"}, 32'(bus.oAddr), 32'((base + t - 1) % DEPTH));
      check({tg, " insel"}, 32'(bus.oInSel), (t >= 2 && t <= n + 1) ? 32'd3 : 32'd0);
      check({tg, " enout"}, 32'(bus.oEnOut), 32'(t == n + 1));
      check({tg, " done"},  32'(bus.oDone),  32'(t == n + 2));
      check({tg, " busy"},  32'(bus.oBusy),  32'(t <= n + 2));
      check({tg, " accout"}, 32'(acc_out),   (t == n + 2) ? 32'(sum) : 32'd0);
   endtask

   // Full burst from T0 through T(N+3); with hold, iStart stays high while
   // busy and the capture inputs are scrambled to show they are ignored.
   task automatic run_burst(input int base, input int n, input bit hold);
      logic [15:0] sum;
      sum = burst_sum(base, n);
      burst_id++;
      bus.iBaseAddr = AW'(base);
      bus.iLen      = LW'(n);
      bus.iStart    = 1'b1;
      step();
      if (!hold) bus.iStart = 1'b0;
      else begin
         bus.iBaseAddr = AW'($urandom);
         bus.iLen      = LW'($urandom_range(1, DEPTH));
      end
      for (int t = 1; t <= n + 3; t++) begin
         check_cycle(t, base, n, sum);
         if (t >= n + 2) bus.iStart = 1'b0;
         step();
      end
   endtask

   task automatic fill_random();
      for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
   endtask

   initial begin
      int b;
      int n;
      rsn           = 1'b0;
      bus.iStart    = 1'b0;
      bus.iBaseAddr = '0;
      bus.iLen      = '0;
      bus.iAbort    = 1'b0;
      fill_random();
      step();
      step();
      check_idle("reset");
      #3 rsn = 1'b1;
      step();
      check_idle("post_reset");

      // Simple sum 1+2+3+4.
      mem[0] = 16'd1; mem[1] = 16'd2; mem[2] = 16'd3; mem[3] = 16'd4;
      check("model_sum4", 32'(burst_sum(0, 4)), 32'd10);
      run_burst(0, 4, 1'b0);

      // Positive saturation over a full-depth burst.
      for (int i = 0; i < DEPTH; i++) mem[i] = 16'h7000;
      run_burst(0, 16, 1'b0);

      // Wrap-around with negative saturation.
      fill_random();
      mem[14] = 16'h8000; mem[15] = 16'h8000; mem[0] = 16'd5; mem[1] = 16'd1;
      check("model_wrap", 32'(burst_sum(14, 4)), 32'h8006);
      run_burst(14, 4, 1'b0);

      // Illegal lengths are ignored.
      bus.iStart = 1'b1; bus.iLen = LW'(0); bus.iBaseAddr = AW'(2);
      step();
      check_idle("len0");
      bus.iLen = LW'(DEPTH + 1);
      step();
      check_idle("len17");
      bus.iStart = 1'b0;
      step();
      check_idle("len_bad_after");

      // Single-word burst.
      mem[3] = 16'h1234;
      run_burst(3, 1, 1'b0);

      // Abort at T3 of an 8-word burst.
      fill_random();
      burst_id++;
      b = int'($urandom_range(0, DEPTH - 1));
      bus.iBaseAddr = AW'(b); bus.iLen = LW'(8); bus.iStart = 1'b1;
      step();
      bus.iStart = 1'b0;
      for (int t = 1; t <= 3; t++) begin
         check_cycle(t, b, 8, 16'h0000);
         if (t < 3) step();
      end
      bus.iAbort = 1'b1;
      step();
      bus.iAbort = 1'b0;
      for (int i = 0; i < 10; i++) begin
         check_idle($sformatf("abort c%0d", i));
         step();
      end

      // Abort together with start: start is ignored.
      bus.iStart = 1'b1; bus.iAbort = 1'b1; bus.iLen = LW'(4); bus.iBaseAddr = '0;
      step();
      bus.iStart = 1'b0; bus.iAbort = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_idle($sformatf("abort_start c%0d", i));
         step();
      end

      // Restart right after the abort.
      run_burst(int'($urandom_range(0, DEPTH - 1)), 2, 1'b0);

      // Asynchronous reset in the middle of ISSUE.
      bus.iBaseAddr = '0; bus.iLen = LW'(8); bus.iStart = 1'b1;
      step();
      bus.iStart = 1'b0;
      check("rst_pre busy", 32'(bus.oBusy), 32'd1);
      step();
      #2 rsn = 1'b0;
      #1 check_idle("rst_async");
      step();
      check_idle("rst_held");
      #3 rsn = 1'b1;
      step();
      check_idle("rst_release");

      // Start held during busy is ignored; a following burst is normal.
      fill_random();
      run_burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, DEPTH)), 1'b1);
      run_burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, DEPTH)), 1'b0);

      // Randomized bursts.
      for (int r = 0; r < 24; r++) begin
         fill_random();
         if ((r % 4) == 0) for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom_range(0, 1) ? 16'h7F00 : 16'h8100);
         b = int'($urandom_range(0, DEPTH - 1));
         n = int'($urandom_range(1, DEPTH));
         run_burst(b, n, 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) step();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_acc_rd_seq
